// File: rtl/cpu_pkg.sv
// Shared pipeline types and constants for the IF/ID path.
package cpu_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one sync write port, one async read port.
module fetch_queue_mem
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = XLEN + ILEN
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (we_i) begin
            r_mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// IF/ID instruction fetch queue with flush, NOP fill and optional bypass.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int              XLEN      = cpu_pkg::XLEN,
    parameter int              ILEN      = cpu_pkg::ILEN,
    parameter int              DEPTH     = 4,
    parameter int              BYPASS    = 0,
    parameter logic [ILEN-1:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       start_i,
    input  logic                       flush_i,
    input  logic                       push_valid_i,
    output logic                       push_ready_o,
    input  logic [XLEN-1:0]            push_pc_i,
    input  logic [ILEN-1:0]            push_instr_i,
    output logic                       pop_valid_o,
    input  logic                       pop_ready_i,
    output logic [XLEN-1:0]            pop_pc_o,
    output logic [ILEN-1:0]            pop_instr_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int W  = XLEN + ILEN;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ready;
    logic          w_byp;
    logic          w_pop_valid;
    logic          w_push_fire;
    logic          w_pop_fire;
    logic          w_wr;
    logic          w_rd;
    logic [W-1:0]  w_rdata;
    logic [W-1:0]  w_head;

    assign w_full       = (r_count == CW'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push_ready = rst_i & start_i & ~w_full;

    // Bypass forwards the IF entry straight to ID while the queue is empty.
    assign w_byp        = (BYPASS != 0) & w_empty & push_valid_i
                        & start_i & ~flush_i;
    assign w_pop_valid  = start_i & ~flush_i & (~w_empty | w_byp);

    assign w_push_fire  = push_valid_i & w_push_ready & ~flush_i;
    assign w_pop_fire   = w_pop_valid & pop_ready_i;

    // A bypassed entry consumed the same cycle never touches storage.
    assign w_wr         = w_push_fire & ~(w_byp & w_pop_fire);
    assign w_rd         = w_pop_fire & ~w_byp;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_wr),
        .waddr_i (r_wr_ptr),
        .wdata_i ({push_pc_i, push_instr_i}),
        .raddr_i (r_rd_ptr),
        .rdata_o (w_rdata)
    );

    assign w_head = w_byp ? {push_pc_i, push_instr_i} : w_rdata;

    assign push_ready_o = w_push_ready;
    assign pop_valid_o  = w_pop_valid;
    assign pop_pc_o     = w_pop_valid ? w_head[W-1:ILEN] : '0;
    assign pop_instr_o  = w_pop_valid ? w_head[ILEN-1:0] : NOP_INSTR;
    assign count_o      = r_count;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: BYPASS=0 and BYPASS=1 instances against a queue model.
module tb_fetch_queue;
    import cpu_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        st    = 1'b0;
    logic        fl    = 1'b0;
    logic        pv    = 1'b0;
    logic        pr    = 1'b0;
    logic [31:0] ppc   = '0;
    logic [31:0] pin   = '0;

    logic        o_prdy [2];
    logic        o_pval [2];
    logic [31:0] o_pc   [2];
    logic [31:0] o_in   [2];
    logic [2:0]  o_cnt  [2];

    int vec  = 0;
    int errs = 0;

    fq_entry_t mq [2][$];
    logic [31:0] got [$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(4), .BYPASS(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .start_i(st), .flush_i(fl),
        .push_valid_i(pv), .push_ready_o(o_prdy[0]),
        .push_pc_i(ppc), .push_instr_i(pin),
        .pop_valid_o(o_pval[0]), .pop_ready_i(pr),
        .pop_pc_o(o_pc[0]), .pop_instr_o(o_in[0]), .count_o(o_cnt[0])
    );

    fetch_queue #(.DEPTH(4), .BYPASS(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_n), .start_i(st), .flush_i(fl),
        .push_valid_i(pv), .push_ready_o(o_prdy[1]),
        .push_pc_i(ppc), .push_instr_i(pin),
        .pop_valid_o(o_pval[1]), .pop_ready_i(pr),
        .pop_pc_o(o_pc[1]), .pop_instr_o(o_in[1]), .count_o(o_cnt[1])
    );

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    function automatic bit e_byp(input int b);
        return b == 1 && mq[b].size() == 0 && pv && st && !fl;
    endfunction

    function automatic bit e_pval(input int b);
        return st && !fl && (mq[b].size() != 0 || e_byp(b));
    endfunction

    function automatic fq_entry_t e_head(input int b);
        fq_entry_t h;
        h = '0;
        if (e_byp(b)) h = '{pc: ppc, instr: pin};
        else if (mq[b].size() != 0) h = mq[b][0];
        return h;
    endfunction

    task automatic step_model(input int b);
        int n;
        bit byp, pf, qf;
        n   = mq[b].size();
        byp = e_byp(b);
        pf  = pv && n != 4;
        qf  = e_pval(b) && pr;
        if (fl) begin
            mq[b].delete();
        end else if (st) begin
            if (!(byp && qf)) begin
                if (qf) void'(mq[b].pop_front());
                if (pf) mq[b].push_back('{pc: ppc, instr: pin});
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq[0].delete();
            mq[1].delete();
        end else begin
            for (int b = 0; b < 2; b++) step_model(b);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int b = 0; b < 2; b++) begin
                fq_entry_t h;
                bit v;
                h = e_head(b);
                v = e_pval(b);
                chk($sformatf("dut%0d push_ready", b), 32'(o_prdy[b]),
                    32'(st && mq[b].size() != 4));
                chk($sformatf("dut%0d pop_valid", b), 32'(o_pval[b]), 32'(v));
                chk($sformatf("dut%0d pop_pc", b), o_pc[b], v ? h.pc : 32'h0);
                chk($sformatf("dut%0d pop_instr", b), o_in[b],
                    v ? h.instr : NOP_INSTR);
                chk($sformatf("dut%0d count", b), 32'(o_cnt[b]),
                    32'(mq[b].size()));
            end
        end
    end

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return 32'h0050_0093 + (pc << 18);
    endfunction

    task automatic drive(input logic s, input logic f, input logic v,
                         input logic [31:0] pc, input logic r);
        @(posedge clk);
        #1;
        st  = s;
        fl  = f;
        pv  = v;
        ppc = pc;
        pin = ins(pc);
        pr  = r;
    endtask

    task automatic chk_reset(input string tag);
        for (int b = 0; b < 2; b++) begin
            chk($sformatf("%s dut%0d count", tag, b), 32'(o_cnt[b]), 0);
            chk($sformatf("%s dut%0d pop_valid", tag, b), 32'(o_pval[b]), 0);
            chk($sformatf("%s dut%0d pop_pc", tag, b), o_pc[b], 0);
            chk($sformatf("%s dut%0d pop_instr", tag, b), o_in[b], NOP_INSTR);
            chk($sformatf("%s dut%0d push_ready", tag, b), 32'(o_prdy[b]), 0);
        end
    endtask

    initial begin
        int n;
        int cyc;
        #1 st = 1'b1;
        #1 chk_reset("reset");
        #5 rst_n = 1'b1;

        // Fill to full, offer a fifth entry, then drain in order.
        for (int i = 0; i < 4; i++) drive(1, 0, 1, 32'(4 * i), 0);
        drive(1, 0, 1, 32'd16, 0);
        #2;
        chk("full count", 32'(o_cnt[0]), 4);
        chk("full push_ready", 32'(o_prdy[0]), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0, 0, 1);
            #2;
            chk($sformatf("drain pc%0d", i), o_pc[0], 32'(4 * i));
            chk($sformatf("drain instr%0d", i), o_in[0], ins(32'(4 * i)));
        end
        drive(1, 0, 0, 0, 0);
        #2 chk("drained count", 32'(o_cnt[0]), 0);

        // Simultaneous push and pop at count 2.
        drive(1, 0, 1, 32'h18, 0);
        drive(1, 0, 1, 32'h1c, 0);
        drive(1, 0, 1, 32'h20, 1);
        #2 chk("pp head", o_pc[0], 32'h18);
        drive(1, 0, 0, 0, 1);
        #2;
        chk("pp count", 32'(o_cnt[0]), 2);
        chk("pp 2nd", o_pc[0], 32'h1c);
        drive(1, 0, 0, 0, 1);
        #2 chk("pp 3rd", o_pc[0], 32'h20);
        drive(1, 0, 0, 0, 0);

        // Stream 10 entries with IF honouring push_ready, ID toggling ready.
        n   = 0;
        cyc = 0;
        got.delete();
        while ((n < 10 || o_cnt[0] != 0) && cyc < 80) begin
            drive(1, 0, n < 10, 32'h100 + 32'(4 * n), cyc % 2 == 0);
            #2;
            if (o_pval[0] && pr) got.push_back(o_pc[0]);
            if (pv && o_prdy[0]) n++;
            cyc++;
        end
        chk("stream count", 32'(got.size()), 10);
        for (int i = 0; i < got.size() && i < 10; i++)
            chk($sformatf("stream pc%0d", i), got[i], 32'h100 + 32'(4 * i));

        // Flush at count 3 with a concurrent push.
        drive(1, 0, 1, 32'h30, 0);
        drive(1, 0, 1, 32'h34, 0);
        drive(1, 0, 1, 32'h38, 0);
        drive(1, 1, 1, 32'h40, 0);
        #2;
        chk("flush pop_valid", 32'(o_pval[0]), 0);
        chk("flush pop_instr", o_in[0], 32'h0000_0013);
        drive(1, 0, 0, 0, 0);
        #2;
        chk("post-flush count", 32'(o_cnt[0]), 0);
        chk("post-flush pop_valid", 32'(o_pval[0]), 0);

        // Same-cycle bypass on the BYPASS=1 instance only.
        drive(1, 0, 1, 32'h80, 1);
        #2;
        chk("byp pop_valid", 32'(o_pval[1]), 1);
        chk("byp pop_pc", o_pc[1], 32'h80);
        chk("nobyp pop_valid", 32'(o_pval[0]), 0);
        drive(1, 0, 0, 0, 0);
        #2;
        chk("byp count", 32'(o_cnt[1]), 0);
        chk("nobyp count", 32'(o_cnt[0]), 1);
        drive(1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0);

        // Asynchronous reset mid-cycle with three entries held.
        drive(1, 0, 1, 32'h50, 0);
        drive(1, 0, 1, 32'h54, 0);
        drive(1, 0, 1, 32'h58, 0);
        drive(1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_reset("async reset");
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("release count", 32'(o_cnt[0]), 0);
        chk("release push_ready", 32'(o_prdy[0]), 32'(st));

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 8) != 0, ($urandom % 16) == 0,
                  ($urandom % 4) != 0, $urandom, $urandom % 2);
            pin = $urandom;
        end
        drive(1, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
